// File: rtl/fifo_agilex7_pkg.sv
// fifo_agilex7_pkg: shared types for the fifo_agilex7 slice.
// The per-cycle operation encoding lets the control block branch on what
// was accepted this cycle rather than on raw request bits.
package fifo_agilex7_pkg;

  // Accepted operation this cycle, encoded as {write, read}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage : fifo_agilex7_pkg

// File: rtl/fifo_agilex7_ram.sv
// fifo_agilex7_ram: simple dual-port WIDTH x DEPTH storage with synchronous
// write and a registered read port. The read register is the FIFO's q, so it
// is cleared by reset; the array itself is never reset. Read-during-write to
// the same address returns the old word (needed when a full FIFO reads and
// writes the same slot in one cycle).
module fifo_agilex7_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int FORCE_MLAB = 1,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rd_word;

  generate
    if (FORCE_MLAB != 0) begin : g_mlab
      (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [0:DEPTH-1];

      // Synchronous write into the MLAB-constrained array
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
      end

      assign rd_word = mem[rd_addr];
    end else begin : g_auto
      logic [WIDTH-1:0] mem [0:DEPTH-1];

      // Synchronous write; memory style left to the tool
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
      end

      assign rd_word = mem[rd_addr];
    end
  endgenerate

  // Registered read port: loads only on an accepted read, otherwise holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (rd_en) begin
      q <= rd_word;
    end
  end

endmodule : fifo_agilex7_ram

// File: rtl/fifo_agilex7.sv
// fifo_agilex7: single-clock, normal-read-mode FIFO with arbitrary DEPTH.
// Control (pointers, occupancy, flags) lives here; storage and the q
// register live in fifo_agilex7_ram.
// Optional feature: define FIFO_AGILEX7_USEDW_EN to expose the occupancy
// count on output usedw.
module fifo_agilex7
  import fifo_agilex7_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int FORCE_MLAB = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data,
  input  logic                       wrreq,
  input  logic                       rdreq,
  output logic [WIDTH-1:0]           q,
`ifdef FIFO_AGILEX7_USEDW_EN
  output logic [$clog2(DEPTH):0]     usedw,
`endif
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rd_acc;
  logic          wr_acc;
  fifo_op_e      op;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2)
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags decode the registered count; no write-to-read bypass
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO may still write
  assign rd_acc = rdreq & ~empty;
  assign wr_acc = wrreq & (~full | rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

`ifdef FIFO_AGILEX7_USEDW_EN
  assign usedw = count;
`endif

  // Pointer and occupancy update; reset discards all contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_agilex7_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .FORCE_MLAB (FORCE_MLAB),
    .AW         (PW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .q       (q)
  );

endmodule : fifo_agilex7

// File: tb/tb_fifo_agilex7.sv
// tb_fifo_agilex7: directed plus randomized checks of fifo_agilex7 at
// DEPTH=2 and DEPTH=3 against a queue-based reference model.
module tb_fifo_agilex7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] data2 = '0, data3 = '0;
  logic       wrreq2 = 1'b0, rdreq2 = 1'b0;
  logic       wrreq3 = 1'b0, rdreq3 = 1'b0;
  logic [7:0] q2, q3;
  logic       empty2, full2, empty3, full3;
`ifdef FIFO_AGILEX7_USEDW_EN
  logic [1:0] usedw2;
  logic [2:0] usedw3;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: contents as queues, last read word as a variable
  logic [7:0] m2[$];
  logic [7:0] m3[$];
  logic [7:0] mq2 = '0, mq3 = '0;

  always #5 clk = ~clk;

  fifo_agilex7 #(.WIDTH(8), .DEPTH(2), .FORCE_MLAB(1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data2),
    .wrreq (wrreq2),
    .rdreq (rdreq2),
    .q     (q2),
`ifdef FIFO_AGILEX7_USEDW_EN
    .usedw (usedw2),
`endif
    .empty (empty2),
    .full  (full2)
  );

  fifo_agilex7 #(.WIDTH(8), .DEPTH(3), .FORCE_MLAB(0)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data3),
    .wrreq (wrreq3),
    .rdreq (rdreq3),
    .q     (q3),
`ifdef FIFO_AGILEX7_USEDW_EN
    .usedw (usedw3),
`endif
    .empty (empty3),
    .full  (full3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int sel);
    if (sel == 2) begin
      chk("d2_q",     32'(q2),     32'(mq2));
      chk("d2_empty", 32'(empty2), 32'(m2.size() == 0));
      chk("d2_full",  32'(full2),  32'(m2.size() == 2));
`ifdef FIFO_AGILEX7_USEDW_EN
      chk("d2_usedw", 32'(usedw2), 32'(m2.size()));
`endif
    end else begin
      chk("d3_q",     32'(q3),     32'(mq3));
      chk("d3_empty", 32'(empty3), 32'(m3.size() == 0));
      chk("d3_full",  32'(full3),  32'(m3.size() == 3));
`ifdef FIFO_AGILEX7_USEDW_EN
      chk("d3_usedw", 32'(usedw3), 32'(m3.size()));
`endif
    end
  endtask

  // One clock of traffic on the selected FIFO; the other FIFO idles.
  task automatic step(input int sel, input bit wr, input bit rd,
                      input logic [7:0] d, output bit ra);
    int sz;
    int depth;
    bit wa;
    if (sel == 2) begin
      wrreq2 = wr; rdreq2 = rd; data2 = d; wrreq3 = 1'b0; rdreq3 = 1'b0;
      sz = m2.size(); depth = 2;
    end else begin
      wrreq3 = wr; rdreq3 = rd; data3 = d; wrreq2 = 1'b0; rdreq2 = 1'b0;
      sz = m3.size(); depth = 3;
    end
    ra = rd && (sz > 0);
    wa = wr && ((sz < depth) || ra);
    @(posedge clk); #1;
    if (sel == 2) begin
      if (ra) mq2 = m2.pop_front();
      if (wa) m2.push_back(d);
    end else begin
      if (ra) mq3 = m3.pop_front();
      if (wa) m3.push_back(d);
    end
    wrreq2 = 1'b0; rdreq2 = 1'b0; wrreq3 = 1'b0; rdreq3 = 1'b0;
    check_model(sel);
  endtask

  task automatic do_reset(input bit wr);
    rst_n = 1'b0;
    wrreq2 = wr; wrreq3 = wr; rdreq2 = 1'b0; rdreq3 = 1'b0;
    data2 = 8'hEE; data3 = 8'hEE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wrreq2 = 1'b0; wrreq3 = 1'b0;
    m2.delete(); m3.delete();
    mq2 = '0; mq3 = '0;
    chk("rst_d2_empty", 32'(empty2), 32'd1);
    chk("rst_d2_full",  32'(full2),  32'd0);
    chk("rst_d2_q",     32'(q2),     32'd0);
    chk("rst_d3_empty", 32'(empty3), 32'd1);
    chk("rst_d3_full",  32'(full3),  32'd0);
    chk("rst_d3_q",     32'(q3),     32'd0);
`ifdef FIFO_AGILEX7_USEDW_EN
    chk("rst_d2_usedw", 32'(usedw2), 32'd0);
    chk("rst_d3_usedw", 32'(usedw3), 32'd0);
`endif
  endtask

  initial begin
    bit ra;
    int exp_next;
    @(posedge clk); #1;
    do_reset(1'b0);

    // Two writes into DEPTH=2
    chk("req033_empty_pre", 32'(empty2), 32'd1);
    step(2, 1, 0, 8'h0A, ra);
    chk("req033_empty_after_first", 32'(empty2), 32'd0);
    chk("req033_full_after_first",  32'(full2),  32'd0);
    step(2, 1, 0, 8'h0B, ra);
    chk("req033_full", 32'(full2), 32'd1);

    // Write while full is ignored; reads return A then B
    step(2, 1, 0, 8'h0C, ra);
    chk("req034_full_hold", 32'(full2), 32'd1);
    step(2, 0, 1, 8'h00, ra);
    chk("req034_rd_a", 32'(q2), 32'h0A);
    step(2, 0, 1, 8'h00, ra);
    chk("req034_rd_b", 32'(q2), 32'h0B);
    chk("req034_empty", 32'(empty2), 32'd1);

    // Simultaneous read and write with one entry
    step(2, 1, 0, 8'h05, ra);
    step(2, 1, 1, 8'h06, ra);
    chk("req035_q5", 32'(q2), 32'h05);
    chk("req035_not_empty", 32'(empty2), 32'd0);
    chk("req035_not_full",  32'(full2),  32'd0);
    step(2, 0, 1, 8'h00, ra);
    chk("req035_q6", 32'(q2), 32'h06);

    // Reads while empty hold q
    for (int i = 0; i < 3; i++) begin
      step(2, 0, 1, 8'h00, ra);
      chk("req036_q_hold", 32'(q2), 32'h06);
      chk("req036_empty",  32'(empty2), 32'd1);
    end

    // Simultaneous read and write when full keeps occupancy
    step(2, 1, 0, 8'h11, ra);
    step(2, 1, 0, 8'h22, ra);
    step(2, 1, 1, 8'h33, ra);
    chk("rw_full_q",    32'(q2),    32'h11);
    chk("rw_full_full", 32'(full2), 32'd1);
    step(2, 0, 1, 8'h00, ra);
    chk("rw_full_next", 32'(q2), 32'h22);
    step(2, 0, 1, 8'h00, ra);
    chk("rw_full_last", 32'(q2), 32'h33);

    // Randomized traffic on DEPTH=2
    for (int i = 0; i < 300; i++)
      step(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ra);

    // Stream across pointer wrap on DEPTH=3
    exp_next = 1;
    for (int k = 1; k <= 10; k++) begin
      step(3, 1, 1, 8'(k), ra);
      if (ra) begin
        chk("req037_order", 32'(q3), 32'(exp_next));
        exp_next++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(3, 0, 1, 8'h00, ra);
      if (ra) begin
        chk("req037_order_drain", 32'(q3), 32'(exp_next));
        exp_next++;
      end
    end
    chk("req037_q_last", 32'(q3), 32'd10);
    chk("req037_empty",  32'(empty3), 32'd1);

    // Randomized traffic on DEPTH=3, biased toward writes then reads
    for (int i = 0; i < 400; i++) begin
      if (i < 200)
        step(3, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), ra);
      else
        step(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom), ra);
    end

    // Reset while full with a write pending
    for (int i = 0; i < 3; i++) step(2, 1, 0, 8'($urandom), ra);
    for (int i = 0; i < 4; i++) step(3, 1, 0, 8'($urandom), ra);
    chk("req038_full_pre_d2", 32'(full2), 32'd1);
    chk("req038_full_pre_d3", 32'(full3), 32'd1);
    do_reset(1'b1);
    step(2, 0, 1, 8'h00, ra);
    chk("req038_rd_after_rst", 32'(q2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_fifo_agilex7
